// File: rtl/fsfifo_drain_pkg.sv
// fsfifo_drain shared types: FSM state encoding and the buffer-room helper.
// No ports; imported by fsfifo_drain.
package fsfifo_drain_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Words that will sit in the output buffer after this edge if no
    // new capture happens: current occupancy plus the word in flight,
    // minus the word leaving this cycle.
    function automatic logic [2:0] pending(
        input logic [1:0] occ,
        input logic       inflight,
        input logic       pop
    );
        return {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    endfunction

endpackage

// File: rtl/fsfifo_drain_skid2.sv
// skid2_buffer: 2-entry FIFO-ordered register buffer with registered head.
// Ports: clk, reset, push/push_data (write), pop (drop head), occ, head_data.
module skid2_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data
);

    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;

    always_ff @(posedge clk) begin
        if (reset) begin
            occ <= 2'd0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    // Data registers need no reset; occupancy qualifies them.
    always_ff @(posedge clk) begin
        case ({push, pop})
            2'b11: begin
                if (occ == 2'd2) begin
                    e0 <= e1;
                    e1 <= push_data;
                end else begin
                    e0 <= push_data;
                end
            end
            2'b10: begin
                if (occ == 2'd0) begin
                    e0 <= push_data;
                end else begin
                    e1 <= push_data;
                end
            end
            2'b01: begin
                e0 <= e1;
            end
            default: ;
        endcase
    end

    assign head_data = e0;

endmodule

// File: rtl/fsfifo_drain.sv
// fsfifo_drain: pops N words from a 1-cycle-latency FIFO read port and
// streams them out (valid/ready, last on word N, done pulse at the end).
// Ports: clk_i, reset_i, cmd_valid_i/cmd_ready_o/cmd_len_i command;
// fifo_empty_i/fifo_rd_o/fifo_data_i FIFO read side; m_valid_o/m_ready_i/
// m_data_o/m_last_o stream; busy_o, done_o status.
module fsfifo_drain
    import fsfifo_drain_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int LEN_BITS = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [LEN_BITS-1:0] cmd_len_i,
    input  logic                fifo_empty_i,
    output logic                fifo_rd_o,
    input  logic [WIDTH-1:0]    fifo_data_i,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic [WIDTH-1:0]    m_data_o,
    output logic                m_last_o,
    output logic                busy_o,
    output logic                done_o
);

    state_t              state;
    state_t              state_nx;
    logic [LEN_BITS-1:0] issue_cnt;
    logic [LEN_BITS-1:0] out_cnt;
    logic                inflight;
    logic                done;
    logic                pop;
    logic                accept;
    logic                finish;
    logic [1:0]          occ;

    assign m_valid_o = (occ != 2'd0);
    assign pop       = m_valid_o && m_ready_i;
    assign m_last_o  = m_valid_o && (out_cnt == LEN_BITS'(1));
    assign done_o    = done;

    always_comb begin
        state_nx    = state;
        cmd_ready_o = 1'b0;
        busy_o      = 1'b0;
        fifo_rd_o   = 1'b0;
        accept      = 1'b0;
        finish      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                accept      = cmd_valid_i;
                if (accept && cmd_len_i != '0) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                // Room check counts the word leaving this cycle, so a
                // full buffer that is draining still issues a read.
                fifo_rd_o = (issue_cnt != '0) && !fifo_empty_i &&
                            (pending(occ, inflight, pop) < 3'd2);
                if (pop && m_last_o) begin
                    finish   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            issue_cnt <= '0;
            out_cnt   <= '0;
            inflight  <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Clearing inflight on reset drops data of a reset-cycle read.
            inflight <= fifo_rd_o;
            done     <= finish || (accept && cmd_len_i == '0);
            if (accept) begin
                issue_cnt <= cmd_len_i;
                out_cnt   <= cmd_len_i;
            end else begin
                if (fifo_rd_o) begin
                    issue_cnt <= issue_cnt - LEN_BITS'(1);
                end
                if (pop) begin
                    out_cnt <= out_cnt - LEN_BITS'(1);
                end
            end
        end
    end

    skid2_buffer #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk       (clk_i),
        .reset     (reset_i),
        .push      (inflight),
        .push_data (fifo_data_i),
        .pop       (pop),
        .occ       (occ),
        .head_data (m_data_o)
    );

endmodule

// File: tb/tb_fsfifo_drain.sv
// Directed bench for fsfifo_drain with a behavioural 1-cycle-latency FIFO.
// Inputs change at negedge; outputs are checked 1ns later.
module tb_fsfifo_drain;

    localparam int W = 32;
    localparam int L = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [L-1:0] cmd_len;
    logic         fifo_empty;
    logic         fifo_rd;
    logic [W-1:0] fifo_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_last;
    logic         busy;
    logic         done;
    logic         wr_en;
    logic [W-1:0] wr_data;

    logic [W-1:0] mem [64];
    logic [5:0]   wptr = '0;
    logic [5:0]   rptr = '0;
    int           rd_count = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    fsfifo_drain #(.WIDTH(W), .LEN_BITS(L)) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_len_i    (cmd_len),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_o    (fifo_rd),
        .fifo_data_i  (fifo_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .m_last_o     (m_last),
        .busy_o       (busy),
        .done_o       (done)
    );

    assign fifo_empty = (wptr == rptr);

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= wr_data;
            wptr      <= wptr + 6'd1;
        end
        if (fifo_rd) begin
            fifo_data <= mem[rptr];
            rptr      <= rptr + 6'd1;
            rd_count  <= rd_count + 1;
        end
    end

    // Back-pressure trace, index = cycle after command edge.
    int bp_rdy [14] = '{1,1,0,0,1,1,0,0,1,1,0,0,1,1};
    int bp_rd  [14] = '{0,1,1,0,1,1,0,0,1,0,0,0,0,0};
    int bp_val [14] = '{0,0,0,1,1,1,1,1,1,1,1,1,1,0};
    int bp_dat [14] = '{0,0,0,0,0,1,2,2,2,3,4,4,4,0};
    int bp_lst [14] = '{0,0,0,0,0,0,0,0,0,0,1,1,1,0};

    task automatic step(
        input logic         r,
        input logic         cv,
        input logic [L-1:0] len,
        input logic         rdy,
        input logic         we = 1'b0,
        input logic [W-1:0] wd = '0
    );
        @(negedge clk);
        reset     = r;
        cmd_valid = cv;
        cmd_len   = len;
        m_ready   = rdy;
        wr_en     = we;
        wr_data   = wd;
        #1;
    endtask

    task automatic chk(
        input string        tag,
        input logic [W-1:0] got,
        input logic [W-1:0] exp
    );
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 0, 1, 1, base + W'(i));
        end
        step(0, 0, 0, 1);
    endtask

    task automatic run_basic(input string nm, input logic [W-1:0] base);
        int r0;
        bit ev;
        step(0, 1, 4, 1);
        r0 = rd_count;
        chk({nm, "_rdy0"}, W'(cmd_ready), 1);
        chk({nm, "_rd0"}, W'(fifo_rd), 0);
        for (int c = 1; c <= 8; c++) begin
            step(0, 0, 0, 1);
            ev = (c >= 3 && c <= 6);
            chk($sformatf("%s_rd_c%0d", nm, c),
                W'(fifo_rd), W'(c <= 4));
            chk($sformatf("%s_val_c%0d", nm, c), W'(m_valid), W'(ev));
            if (ev) begin
                chk($sformatf("%s_dat_c%0d", nm, c),
                    m_data, base + W'(c - 3));
            end
            chk($sformatf("%s_last_c%0d", nm, c),
                W'(m_last), W'(c == 6));
            chk($sformatf("%s_done_c%0d", nm, c),
                W'(done), W'(c == 7));
            chk($sformatf("%s_busy_c%0d", nm, c),
                W'(busy), W'(c <= 6));
        end
        chk({nm, "_nreads"}, W'(rd_count - r0), 4);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        m_ready   = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;

        // Reset state
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_cmd_ready", W'(cmd_ready), 1);
        chk("rst_busy", W'(busy), 0);
        chk("rst_valid", W'(m_valid), 0);
        chk("rst_done", W'(done), 0);
        chk("rst_rd", W'(fifo_rd), 0);
        chk("rst_last", W'(m_last), 0);

        // Basic drain
        preload(32'hA0, 4);
        run_basic("basic", 32'hA0);

        // Back-pressure
        preload(32'hB0, 5);
        step(0, 1, 5, 1);
        for (int c = 1; c <= 13; c++) begin
            step(0, 0, 0, bp_rdy[c][0]);
            chk($sformatf("bp_rd_c%0d", c), W'(fifo_rd), W'(bp_rd[c]));
            chk($sformatf("bp_val_c%0d", c), W'(m_valid), W'(bp_val[c]));
            if (bp_val[c] != 0) begin
                chk($sformatf("bp_dat_c%0d", c),
                    m_data, 32'hB0 + W'(bp_dat[c]));
            end
            chk($sformatf("bp_last_c%0d", c), W'(m_last), W'(bp_lst[c]));
            chk($sformatf("bp_done_c%0d", c), W'(done), W'(c == 13));
        end

        // Underrun
        preload(32'hC0, 1);
        step(0, 1, 3, 1);
        step(0, 0, 0, 1);
        chk("ur_rd_c1", W'(fifo_rd), 1);
        step(0, 0, 0, 1);
        chk("ur_rd_c2", W'(fifo_rd), 0);
        step(0, 0, 0, 1);
        chk("ur_val_c3", W'(m_valid), 1);
        chk("ur_dat_c3", m_data, 32'hC0);
        chk("ur_last_c3", W'(m_last), 0);
        chk("ur_rd_c3", W'(fifo_rd), 0);
        for (int c = 4; c <= 12; c++) begin
            step(0, 0, 0, 1);
            chk($sformatf("ur_rd_c%0d", c), W'(fifo_rd), 0);
            chk($sformatf("ur_val_c%0d", c), W'(m_valid), 0);
            chk($sformatf("ur_busy_c%0d", c), W'(busy), 1);
            chk($sformatf("ur_done_c%0d", c), W'(done), 0);
        end
        step(0, 0, 0, 1, 1, 32'hC1);
        chk("ur_rd_c13", W'(fifo_rd), 0);
        step(0, 0, 0, 1, 1, 32'hC2);
        chk("ur_rd_c14", W'(fifo_rd), 1);
        step(0, 0, 0, 1);
        chk("ur_rd_c15", W'(fifo_rd), 1);
        chk("ur_val_c15", W'(m_valid), 0);
        step(0, 0, 0, 1);
        chk("ur_dat_c16", m_data, 32'hC1);
        chk("ur_last_c16", W'(m_last), 0);
        chk("ur_done_c16", W'(done), 0);
        step(0, 0, 0, 1);
        chk("ur_dat_c17", m_data, 32'hC2);
        chk("ur_last_c17", W'(m_last), 1);
        step(0, 0, 0, 1);
        chk("ur_done_c18", W'(done), 1);
        chk("ur_busy_c18", W'(busy), 0);

        // Zero length (FIFO holds words that must not be read)
        preload(32'hD0, 5);
        step(0, 1, 0, 1);
        chk("z_cmd_ready", W'(cmd_ready), 1);
        step(0, 0, 0, 1);
        chk("z_done_c1", W'(done), 1);
        chk("z_busy_c1", W'(busy), 0);
        chk("z_rd_c1", W'(fifo_rd), 0);
        chk("z_val_c1", W'(m_valid), 0);
        step(0, 0, 0, 1);
        chk("z_done_c2", W'(done), 0);
        chk("z_rd_c2", W'(fifo_rd), 0);
        chk("z_val_c2", W'(m_valid), 0);

        // Back-to-back
        step(0, 1, 2, 1);
        step(0, 0, 0, 1);
        chk("bb_rd_c1", W'(fifo_rd), 1);
        step(0, 0, 0, 1);
        chk("bb_rd_c2", W'(fifo_rd), 1);
        step(0, 0, 0, 1);
        chk("bb_dat_c3", m_data, 32'hD0);
        chk("bb_last_c3", W'(m_last), 0);
        step(0, 0, 0, 1);
        chk("bb_dat_c4", m_data, 32'hD1);
        chk("bb_last_c4", W'(m_last), 1);
        step(0, 1, 3, 1);
        chk("bb_done_c5", W'(done), 1);
        chk("bb_cmd_ready_c5", W'(cmd_ready), 1);
        chk("bb_val_c5", W'(m_valid), 0);
        step(0, 0, 0, 1);
        chk("bb_busy_c6", W'(busy), 1);
        chk("bb_rd_c6", W'(fifo_rd), 1);
        step(0, 0, 0, 1);
        chk("bb_rd_c7", W'(fifo_rd), 1);
        step(0, 0, 0, 1);
        chk("bb_rd_c8", W'(fifo_rd), 1);
        chk("bb_dat_c8", m_data, 32'hD2);
        chk("bb_last_c8", W'(m_last), 0);
        step(0, 0, 0, 1);
        chk("bb_dat_c9", m_data, 32'hD3);
        chk("bb_last_c9", W'(m_last), 0);
        step(0, 0, 0, 1);
        chk("bb_dat_c10", m_data, 32'hD4);
        chk("bb_last_c10", W'(m_last), 1);
        step(0, 0, 0, 1);
        chk("bb_done_c11", W'(done), 1);

        // Reset mid-command: buffer full and a read issued
        preload(32'hE0, 8);
        step(0, 1, 8, 0);
        step(0, 0, 0, 0);
        chk("mr_rd_c1", W'(fifo_rd), 1);
        step(0, 0, 0, 0);
        chk("mr_rd_c2", W'(fifo_rd), 1);
        step(0, 0, 0, 0);
        chk("mr_rd_c3", W'(fifo_rd), 0);
        chk("mr_dat_c3", m_data, 32'hE0);
        step(1, 0, 0, 1);
        chk("mr_rd_c4", W'(fifo_rd), 1);
        chk("mr_val_c4", W'(m_valid), 1);
        step(0, 0, 0, 0);
        chk("mr_val_c5", W'(m_valid), 0);
        chk("mr_cmd_ready_c5", W'(cmd_ready), 1);
        chk("mr_busy_c5", W'(busy), 0);
        chk("mr_done_c5", W'(done), 0);
        chk("mr_last_c5", W'(m_last), 0);
        chk("mr_rd_c5", W'(fifo_rd), 0);
        step(0, 0, 0, 1);
        chk("mr_val_c6", W'(m_valid), 0);
        step(0, 0, 0, 1);
        chk("mr_val_c7", W'(m_valid), 0);

        // Restart after reset: E0..E2 were consumed, E3 onward remain
        run_basic("post", 32'hE3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
